// File: rtl/counter_sequencer_if.sv
// Interface bundling the config, control and counter-side signals of the
// interval-timer sequencer. The sequencer connects through the slave modport.
interface counter_sequencer_if #(
  parameter int N  = 8,
  parameter int PW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [N-1:0]  cfg_start;
  logic [N-1:0]  cfg_period;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_periodic;
  logic          start;
  logic          stop;
  logic          pause;
  logic          cnt_load;
  logic          cnt_en;
  logic [N-1:0]  cnt_load_data;
  logic [N-1:0]  cnt_count;
  logic          busy;
  logic          done;
  logic [7:0]    period_count;

  modport slave (
    input  cfg_valid, cfg_start, cfg_period, cfg_prescale, cfg_periodic,
    input  start, stop, pause, cnt_count,
    output cfg_ready, cnt_load, cnt_en, cnt_load_data, busy, done, period_count
  );

  modport master (
    output cfg_valid, cfg_start, cfg_period, cfg_prescale, cfg_periodic,
    output start, stop, pause, cnt_count,
    input  cfg_ready, cnt_load, cnt_en, cnt_load_data, busy, done, period_count
  );
endinterface

// File: rtl/counter_sequencer.sv
// Interval-timer controller driving an external load/enable up-counter.
// Holds a captured config, prescales the count rate, detects terminal count
// and reports it with a one-cycle done pulse.
//
//   state  | meaning
//   IDLE   | waiting for start, config accepted
//   LOAD   | one cycle, counter loaded with start value
//   RUN    | prescaler and counter advancing
//   PAUSED | held by pause level
//   DONE   | one-shot finished, config accepted, start reruns
module counter_sequencer #(
  parameter int N  = 8,
  parameter int PW = 8
) (
  input  logic clk,
  input  logic reset,
  counter_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_start_val;
  logic [N-1:0]  r_period_val;
  logic [PW-1:0] r_prescale;
  logic          r_periodic;
  logic          r_cfg_loaded;
  logic [PW-1:0] r_prescaler;
  logic [7:0]    r_period_count;

  logic w_cfg_ready;
  logic w_capture;
  logic w_active;
  logic w_tick;
  logic w_terminal;

  assign w_cfg_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_capture   = bus.cfg_valid && w_cfg_ready;

  // PAUSED with pause released counts like RUN, so the added delay equals
  // exactly the number of cycles pause was high.
  assign w_active   = ((r_state == S_RUN) || (r_state == S_PAUSED)) && !bus.stop && !bus.pause;
  assign w_tick     = w_active && (r_prescaler == r_prescale);
  assign w_terminal = w_tick && (bus.cnt_count == r_period_val);

  assign bus.cfg_ready     = w_cfg_ready;
  assign bus.busy          = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSED);
  assign bus.cnt_load      = !bus.stop && ((r_state == S_LOAD) || (w_terminal && r_periodic));
  assign bus.cnt_en        = w_tick && !w_terminal;
  assign bus.done          = w_terminal;
  assign bus.cnt_load_data = r_start_val;
  assign bus.period_count  = r_period_count;

  // Config capture, sequencing state, prescaler and period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_start_val    <= '0;
      r_period_val   <= '0;
      r_prescale     <= '0;
      r_periodic     <= 1'b0;
      r_cfg_loaded   <= 1'b0;
      r_prescaler    <= '0;
      r_period_count <= '0;
    end else begin
      if (w_capture) begin
        r_start_val  <= bus.cfg_start;
        r_period_val <= bus.cfg_period;
        r_prescale   <= bus.cfg_prescale;
        r_periodic   <= bus.cfg_periodic;
        r_cfg_loaded <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.stop)
            r_state <= S_IDLE;
          else if (bus.start && (r_cfg_loaded || w_capture))
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else begin
            r_prescaler    <= '0;
            r_period_count <= '0;
            r_state        <= S_RUN;
          end
        end
        S_RUN, S_PAUSED: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else if (bus.pause) begin
            r_state <= S_PAUSED;
          end else begin
            r_state <= S_RUN;
            if (w_tick) begin
              r_prescaler <= '0;
              if (w_terminal) begin
                if (r_period_count != 8'hFF)
                  r_period_count <= r_period_count + 8'd1;
                if (!r_periodic)
                  r_state <= S_DONE;
              end
            end else begin
              r_prescaler <= r_prescaler + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (N=8 and N=4), each driving a
// behavioural up-counter. Expected done pulses are queued by the stimulus and
// checked by an independent monitor.
module tb_counter_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;

  typedef struct {
    int   tag;
    int   cyc;
    logic load;
  } exp_t;
  exp_t exp_q[$];

  counter_sequencer_if #(.N(8), .PW(8)) if8 ();
  counter_sequencer_if #(.N(4), .PW(8)) if4 ();

  counter_sequencer #(.N(8), .PW(8)) dut  (.clk(clk), .reset(reset), .bus(if8.slave));
  counter_sequencer #(.N(4), .PW(8)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  logic [7:0] cnt8;
  logic [3:0] cnt4;

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle index used to time expected events.
  always @(posedge clk) cyc <= cyc + 1;

  // External counters driven by the sequencers' strobes.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt8 <= '0;
      cnt4 <= '0;
    end else begin
      if (if8.cnt_load) cnt8 <= if8.cnt_load_data;
      else if (if8.cnt_en) cnt8 <= cnt8 + 8'd1;
      if (if4.cnt_load) cnt4 <= if4.cnt_load_data;
      else if (if4.cnt_en) cnt4 <= cnt4 + 4'd1;
    end
  end
  assign if8.cnt_count = cnt8;
  assign if4.cnt_count = cnt4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_done(input int tag, input logic load);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL done_unexpected: dut %0d pulsed done at cycle %0d, none expected", tag, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.tag != tag || e.cyc != cyc || e.load !== load) begin
        errors++;
        $display("FAIL done_event: got dut %0d cycle %0d load %0b expected dut %0d cycle %0d load %0b",
                 tag, cyc, load, e.tag, e.cyc, e.load);
      end
    end
  endtask

  // Monitor: compares every done pulse against the queue, checks strobe exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      if (if8.cnt_en) en_cnt++;
      if (if8.cnt_load && if8.cnt_en) begin
        checks++;
        errors++;
        $display("FAIL load_en_excl: cnt_load=1 cnt_en=1 expected not both (cycle %0d)", cyc);
      end
      if (if8.done) pop_done(0, if8.cnt_load);
      if (if4.done) pop_done(1, if4.cnt_load);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int tag, input int c, input logic load);
    exp_t e;
    e.tag = tag; e.cyc = c; e.load = load;
    exp_q.push_back(e);
  endtask

  task automatic cfg8(input logic [7:0] s, input logic [7:0] p, input logic [7:0] ps, input logic per);
    if8.cfg_start = s; if8.cfg_period = p; if8.cfg_prescale = ps; if8.cfg_periodic = per;
    if8.cfg_valid = 1'b1;
  endtask

  task automatic cfg4(input logic [3:0] s, input logic [3:0] p, input logic [7:0] ps, input logic per);
    if4.cfg_start = s; if4.cfg_period = p; if4.cfg_prescale = ps; if4.cfg_periodic = per;
    if4.cfg_valid = 1'b1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t;
  int en_base;

  initial begin
    if8.cfg_valid = 0; if8.cfg_start = 0; if8.cfg_period = 0; if8.cfg_prescale = 0;
    if8.cfg_periodic = 0; if8.start = 0; if8.stop = 0; if8.pause = 0;
    if4.cfg_valid = 0; if4.cfg_start = 0; if4.cfg_period = 0; if4.cfg_prescale = 0;
    if4.cfg_periodic = 0; if4.start = 0; if4.stop = 0; if4.pause = 0;

    // Reset values
    step(2);
    chk("rst_cfg_ready", if8.cfg_ready, 1);
    chk("rst_busy", if8.busy, 0);
    chk("rst_cnt_load", if8.cnt_load, 0);
    chk("rst_cnt_en", if8.cnt_en, 0);
    chk("rst_done", if8.done, 0);
    chk("rst_load_data", if8.cnt_load_data, 0);
    chk("rst_period_count", if8.period_count, 0);
    reset = 1'b0;
    step(1);

    // start without any config is ignored
    if8.start = 1'b1;
    step(1);
    if8.start = 1'b0;
    chk("nocfg_busy", if8.busy, 0);
    chk("nocfg_load", if8.cnt_load, 0);
    step(1);
    chk("nocfg_busy2", if8.busy, 0);

    // One-shot start=2 period=5 prescale=0, config and start together
    t = cyc;
    cfg8(8'd2, 8'd5, 8'd0, 1'b0);
    if8.start = 1'b1;
    push(0, t + 5, 1'b0);
    step(1);
    if8.cfg_valid = 1'b0; if8.start = 1'b0;
    chk("t1_load", if8.cnt_load, 1);
    chk("t1_load_data", if8.cnt_load_data, 2);
    chk("t1_busy", if8.busy, 1);
    chk("t1_cfg_ready", if8.cfg_ready, 0);
    en_base = en_cnt;
    step(5);
    chk("t1_en_pulses", en_cnt - en_base, 3);
    chk("t1_busy_done", if8.busy, 0);
    chk("t1_cfg_ready_done", if8.cfg_ready, 1);
    chk("t1_period_count", if8.period_count, 1);
    chk("t1_counter", cnt8, 5);

    // Same config rerun from DONE with pause high for 10 cycles
    t = cyc;
    if8.start = 1'b1;
    push(0, t + 15, 1'b0);
    step(1);
    if8.start = 1'b0;
    step(2);
    if8.pause = 1'b1;
    en_base = en_cnt;
    step(10);
    if8.pause = 1'b0;
    chk("t3_en_frozen", en_cnt - en_base, 0);
    chk("t3_counter_frozen", cnt8, 3);
    chk("t3_busy", if8.busy, 1);
    step(3);
    chk("t3_busy_done", if8.busy, 0);
    chk("t3_period_count", if8.period_count, 1);

    // Periodic start=0 period=2 prescale=3, new config and start in DONE
    t = cyc;
    cfg8(8'd0, 8'd2, 8'd3, 1'b1);
    if8.start = 1'b1;
    push(0, t + 13, 1'b1);
    push(0, t + 25, 1'b1);
    push(0, t + 37, 1'b1);
    step(1);
    if8.cfg_valid = 1'b0; if8.start = 1'b0;
    chk("t2_load_data", if8.cnt_load_data, 0);
    step(13);
    chk("t2_pc1", if8.period_count, 1);
    step(12);
    chk("t2_pc2", if8.period_count, 2);
    step(12);
    chk("t2_pc3", if8.period_count, 3);
    chk("t2_busy", if8.busy, 1);
    chk("t2_reload", cnt8, 0);
    step(3);
    // stop on a tick cycle: strobes suppressed
    if8.stop = 1'b1;
    #1;
    chk("stop_en", if8.cnt_en, 0);
    chk("stop_load", if8.cnt_load, 0);
    chk("stop_done", if8.done, 0);
    step(1);
    if8.stop = 1'b0;
    chk("stop_busy", if8.busy, 0);
    chk("stop_cfg_ready", if8.cfg_ready, 1);

    // start alone reruns retained periodic config, then stop in RUN
    t = cyc;
    if8.start = 1'b1;
    push(0, t + 13, 1'b1);
    step(1);
    if8.start = 1'b0;
    step(13);
    chk("t4_pc", if8.period_count, 1);
    chk("t4_busy", if8.busy, 1);
    if8.stop = 1'b1;
    step(1);
    if8.stop = 1'b0;
    chk("t4_stop_busy", if8.busy, 0);

    // N=4 wrap: start=14 period=1 prescale=0
    t = cyc;
    cfg4(4'd14, 4'd1, 8'd0, 1'b0);
    if4.start = 1'b1;
    push(1, t + 5, 1'b0);
    step(1);
    if4.cfg_valid = 1'b0; if4.start = 1'b0;
    chk("t5_load", if4.cnt_load, 1);
    chk("t5_load_data", if4.cnt_load_data, 14);
    step(5);
    chk("t5_busy", if4.busy, 0);
    chk("t5_pc", if4.period_count, 1);
    chk("t5_counter", cnt4, 1);
    // new config with start in DONE: start=3 period=4 prescale=1
    t = cyc;
    cfg4(4'd3, 4'd4, 8'd1, 1'b0);
    if4.start = 1'b1;
    push(1, t + 5, 1'b0);
    step(1);
    if4.cfg_valid = 1'b0; if4.start = 1'b0;
    chk("t5b_load_data", if4.cnt_load_data, 3);
    step(5);
    chk("t5b_busy", if4.busy, 0);
    chk("t5b_counter", cnt4, 4);

    // Reset mid-RUN discards config
    if8.start = 1'b1;
    step(1);
    if8.start = 1'b0;
    step(4);
    chk("t6_busy_before", if8.busy, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_busy", if8.busy, 0);
    chk("t6_cfg_ready", if8.cfg_ready, 1);
    chk("t6_load", if8.cnt_load, 0);
    chk("t6_en", if8.cnt_en, 0);
    chk("t6_done", if8.done, 0);
    chk("t6_load_data", if8.cnt_load_data, 0);
    chk("t6_pc", if8.period_count, 0);
    step(1);
    reset = 1'b0;
    if8.start = 1'b1;
    step(1);
    if8.start = 1'b0;
    chk("t6_nocfg_busy", if8.busy, 0);
    chk("t6_nocfg_load", if8.cnt_load, 0);
    step(3);
    chk("t6_nocfg_busy2", if8.busy, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
